pipelined_adder_arbiter: RTL and testbench

Shares one fixed-latency pipelined adder between `NUM_REQ` requesters.
- Each cycle, at most one pending request is granted round-robin.
- The granted operands go into an internal `NUM_REG`-stage adder pipeline, and the requester index travels alongside in a tag pipeline.
- The sum is returned exactly `NUM_REG` cycles later, tagged with the originating requester.
- Per-requester outstanding-credit counters stop any requester from exceeding its response buffering. The block sits between the arithmetic datapath and its client units.

---
 rtl/pipelined_adder_arbiter.sv | 152 +++++++++++++++
 tb/tb_pipelined_adder_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined adder between NUM_REQ requesters.
// Optional statistics counters (stat_issued, stat_blocked) are built when PADD_ARB_STATS_EN is defined.
module pipelined_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int INP_DW  = 8,
    parameter int NUM_REG = 4,
    parameter int MAX_OUT = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*INP_DW-1:0]   req_a,
    input  logic [NUM_REQ*INP_DW-1:0]   req_b,
    output logic                        rsp_valid,
    output logic [INP_DW:0]             rsp_data,
    output logic [ID_W-1:0]             rsp_id
`ifdef PADD_ARB_STATS_EN
    ,
    output logic [31:0]                 stat_issued,
    output logic [31:0]                 stat_blocked
`endif
);

    localparam int CW = $clog2(MAX_OUT + 1);

    // Handshake: requester i hands over its operands on a rising edge where
    // req_valid[i] && req_ready[i]; req_ready is a function of req_valid, the
    // credit counters and ptr only, never of itself. Responses are never stalled.

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [ID_W-1:0]    idx;
    logic [CW-1:0]      outstanding [NUM_REQ];

    logic               vld   [NUM_REG];
    logic [ID_W-1:0]    tag_q [NUM_REG];
    logic [INP_DW:0]    sum_q [NUM_REG];

    logic [INP_DW-1:0]  op_a;
    logic [INP_DW-1:0]  op_b;
    logic [INP_DW:0]    sum_in;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding[i] < CW'(MAX_OUT));
        end
    end

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_any && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
        if (rst) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    assign req_ready = grant;
    assign ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign op_a   = req_a[int'(grant_id)*INP_DW +: INP_DW];
    assign op_b   = req_b[int'(grant_id)*INP_DW +: INP_DW];
    assign sum_in = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= ptr_next;
        end
    end

    // Tag and sum only load behind a valid beat, so the final stage holds its
    // last result while rsp_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_REG; s++) begin
                vld[s]   <= 1'b0;
                tag_q[s] <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            vld[0] <= grant_any;
            if (grant_any) begin
                tag_q[0] <= grant_id;
                sum_q[0] <= sum_in;
            end
            for (int s = 1; s < NUM_REG; s++) begin
                vld[s] <= vld[s-1];
                if (vld[s-1]) begin
                    tag_q[s] <= tag_q[s-1];
                    sum_q[s] <= sum_q[s-1];
                end
            end
        end
    end

    assign rsp_valid = vld[NUM_REG-1];
    assign rsp_data  = sum_q[NUM_REG-1];
    assign rsp_id    = tag_q[NUM_REG-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !(rsp_valid && rsp_id == ID_W'(i))) begin
                    outstanding[i] <= outstanding[i] + 1'b1;
                end else if (!grant[i] && rsp_valid && rsp_id == ID_W'(i)) begin
                    outstanding[i] <= outstanding[i] - 1'b1;
                end
            end
        end
    end

`ifdef PADD_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_blocked <= '0;
        end else begin
            if (grant_any && stat_issued != '1) begin
                stat_issued <= stat_issued + 1'b1;
            end
            if ((|req_valid) && !grant_any && stat_blocked != '1) begin
                stat_blocked <= stat_blocked + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipelined_adder_arbiter.sv
// Self-checking bench for pipelined_adder_arbiter: directed scenarios plus random
// traffic compared against a due-time queue model of the shared adder.
module tb_pipelined_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int INP_DW  = 8;
  localparam int NUM_REG = 4;
  localparam int MAX_OUT = 2;
  localparam int ID_W    = 2;
  localparam int QW      = 32 + ID_W + INP_DW + 1;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*INP_DW-1:0] req_a;
  logic [NUM_REQ*INP_DW-1:0] req_b;
  logic                      rsp_valid;
  logic [INP_DW:0]           rsp_data;
  logic [ID_W-1:0]           rsp_id;
`ifdef PADD_ARB_STATS_EN
  logic [31:0]               stat_issued;
  logic [31:0]               stat_blocked;
`endif

  pipelined_adder_arbiter #(
    .NUM_REQ(NUM_REQ),
    .INP_DW (INP_DW),
    .NUM_REG(NUM_REG),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id)
`ifdef PADD_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_blocked(stat_blocked)
`endif
  );

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: each entry is {due cycle, requester id, sum}
  logic [QW-1:0]       exp_q[$];
  int                  m_out[NUM_REQ];
  int                  m_ptr;
  int                  cyc;
  int                  m_issued;
  int                  m_blocked;
  logic [INP_DW:0]     m_data;
  logic [ID_W-1:0]     m_id;

  logic [NUM_REQ-1:0]  obs_ready;
  logic                obs_rv;
  logic [INP_DW:0]     obs_data;
  logic [ID_W-1:0]     obs_id;

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) m_out[i] = 0;
    m_ptr     = 0;
    m_data    = '0;
    m_id      = '0;
    m_issued  = 0;
    m_blocked = 0;
  endtask

  // Drive one cycle (called at a negedge), check against the model, advance one edge.
  task automatic step(input logic [NUM_REQ-1:0] v,
                      input logic [NUM_REQ*INP_DW-1:0] a,
                      input logic [NUM_REQ*INP_DW-1:0] b);
    logic               exp_rv;
    logic [QW-1:0]      head;
    logic [NUM_REQ-1:0] exp_ready;
    logic [INP_DW-1:0]  oa;
    logic [INP_DW-1:0]  ob;
    logic [INP_DW:0]    s;
    int                 g;
    int                 idx;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    exp_rv = 1'b0;
    head   = '0;
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      if (head[QW-1 -: 32] == 32'(cyc)) begin
        exp_rv = 1'b1;
        void'(exp_q.pop_front());
        m_id   = head[INP_DW+1 +: ID_W];
        m_data = head[INP_DW:0];
      end
    end
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (g < 0 && v[ID_W'(idx)] && m_out[idx] < MAX_OUT) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready = NUM_REQ'(1) << g;

    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("rsp_data",  32'(rsp_data),  32'(m_data));
    check("rsp_id",    32'(rsp_id),    32'(m_id));
    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_data  = rsp_data;
    obs_id    = rsp_id;

    // a credit returned this cycle only matters from the next cycle on
    if (exp_rv) m_out[m_id]--;
    if (g >= 0) begin
      oa = a[g*INP_DW +: INP_DW];
      ob = b[g*INP_DW +: INP_DW];
      s  = {1'b0, oa} + {1'b0, ob};
      exp_q.push_back({32'(cyc + NUM_REG), ID_W'(g), s});
      m_out[g]++;
      m_ptr = (g + 1) % NUM_REQ;
      m_issued++;
    end else if (|v) begin
      m_blocked++;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0);
  endtask

  // Assert reset between edges with all requesters valid, hold over one edge.
  task automatic do_reset();
    req_valid = '1;
    rst       = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
`ifdef PADD_ARB_STATS_EN
    check("rst_stat_issued",  stat_issued,  32'd0);
    check("rst_stat_blocked", stat_blocked, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [NUM_REQ*INP_DW-1:0] pa;
  logic [NUM_REQ*INP_DW-1:0] pb;
  int credit_exp[6] = '{1, 1, 0, 0, 0, 1};
  int simul_exp[3]  = '{2, 2, 0};

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_data",  32'(rsp_data),  32'd0);
    check("reset_rsp_id",    32'(rsp_id),    32'd0);
    rst = 1'b0;

    // latency: requester 2 alone, 0x7F + 0x01
    pa = '0; pb = '0;
    pa[2*INP_DW +: INP_DW] = 8'h7F;
    pb[2*INP_DW +: INP_DW] = 8'h01;
    step(4'b0100, pa, pb);
    check("lat_ready", 32'(obs_ready), 32'h4);
    idle(3);
    step('0, '0, '0);
    check("lat_rsp_valid", 32'(obs_rv),   32'd1);
    check("lat_rsp_data",  32'(obs_data), 32'h080);
    check("lat_rsp_id",    32'(obs_id),   32'd2);
    step('0, '0, '0);
    check("lat_rsp_gone",  32'(obs_rv),   32'd0);

    // credit limit: requester 0 continuously valid
    for (int i = 0; i < 6; i++) begin
      pa = $urandom;
      pb = $urandom;
      step(4'b0001, pa, pb);
      check("credit_ready", 32'(obs_ready), 32'(credit_exp[i]));
    end
    idle(NUM_REG + 1);

    // simultaneous issue and credit return for requester 1
    pa = $urandom; pb = $urandom;
    step(4'b0010, pa, pb);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      pa = $urandom; pb = $urandom;
      step(4'b0010, pa, pb);
      check("simul_ready", 32'(obs_ready), 32'(simul_exp[i]));
    end
    idle(NUM_REG + 2);

    // round-robin rotation from ptr=0, with a carry case on requester 0
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pa = $urandom; pb = $urandom;
      if (k == 0) begin
        pa[INP_DW-1:0] = 8'hFF;
        pb[INP_DW-1:0] = 8'hFF;
      end
      step(4'b1111, pa, pb);
      check("rr_grant", 32'(obs_ready), 32'(1) << (k % NUM_REQ));
      if (k == 4) begin
        check("rr_carry_data", 32'(obs_data), 32'h1FE);
        check("rr_carry_id",   32'(obs_id),   32'd0);
      end
    end
    idle(NUM_REG + 2);

    // reset mid-flight: in-flight results must vanish
    for (int k = 0; k < 3; k++) begin
      pa = $urandom; pb = $urandom;
      step(4'b1111, pa, pb);
    end
    do_reset();
    pa = $urandom; pb = $urandom;
    step(4'b1111, pa, pb);
    check("post_rst_grant", 32'(obs_ready), 32'h1);
    idle(3);
    step('0, '0, '0);
    check("post_rst_rsp", 32'(obs_rv), 32'd1);
    idle(2);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      pa = $urandom; pb = $urandom;
      step(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)), pa, pb);
    end
    idle(NUM_REG + 2);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

`ifdef PADD_ARB_STATS_EN
    check("stat_issued",  stat_issued,  32'(m_issued));
    check("stat_blocked", stat_blocked, 32'(m_blocked));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
